// File: rtl/ma_ctrl_pkg.sv
// Shared types and sizing for the matrix-accelerator job sequencer.
// Kernel edge, slot counts, operand width and the sequencer state encoding.
package ma_ctrl_pkg;

    localparam int KERNEL_SIZE_DEF = 3;
    localparam int N               = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
    localparam int SLOT_W          = $clog2(N);
    localparam int OP_W            = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ma_job_sequencer_if.sv
// Host-side bundle of the job sequencer: kernel writes, window stream and result stream.
// The master modport is the host fabric and the slave modport is the sequencer.
interface ma_job_sequencer_if
    import ma_ctrl_pkg::*;
#(
    parameter int SLOT_BITS = SLOT_W
);

    logic                 kern_wr_en;
    logic [SLOT_BITS-1:0] kern_wr_addr;
    logic [OP_W-1:0]      kern_wr_data;

    logic                 win_valid;
    logic                 win_ready;
    logic [OP_W-1:0]      win_data;

    logic                 res_valid;
    logic                 res_ready;
    logic [OP_W-1:0]      res_data;

    modport master (
        output kern_wr_en, kern_wr_addr, kern_wr_data,
        output win_valid, win_data,
        input  win_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  kern_wr_en, kern_wr_addr, kern_wr_data,
        input  win_valid, win_data,
        output win_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/ma_operand_bank.sv
// DEPTH x DW register file with indexed write, synchronous clear and a flat read-out bus.
// Slot k of the flat bus sits at [k*DW +: DW].
module ma_operand_bank
    import ma_ctrl_pkg::*;
#(
    parameter int DEPTH = N,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = OP_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    output logic [DEPTH*DW-1:0] flat
);

    // Clear wins over write so a reset on the same cycle as a write leaves the bank empty.
    always_ff @(posedge clk) begin
        if (clr) begin
            flat <= '0;
        end else if (we) begin
            flat[waddr*DW +: DW] <= wdata;
        end
    end

endmodule

// File: rtl/ma_job_sequencer.sv
// Job sequencer for the integer matrix accelerator: kernel bank, window collection, mStart, result return.
// Optional watchdog on the accelerator response is enabled by defining MA_TIMEOUT_EN.
module ma_job_sequencer
    import ma_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE**4),
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    ma_job_sequencer_if.slave                         host,
    input  logic                                      cfg_direct,
    input  logic [ADDR_WIDTH-1:0]                     cfg_addr_sel,
    output logic                                      busy,
    output logic                                      err,
    output logic [KERNEL_SIZE*KERNEL_SIZE*OP_W-1:0]   ma_multiplier,
    output logic [KERNEL_SIZE*KERNEL_SIZE*OP_W-1:0]   ma_multiplicand,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]        ma_mstart,
    output logic                                      ma_direct,
    output logic [ADDR_WIDTH-1:0]                     ma_address_select,
    input  logic [OP_W-1:0]                           ma_final_accumulate,
    input  logic                                      ma_final_ready
);

    localparam int NSLOT     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int SLOT_BITS = $clog2(NSLOT);
    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NSLOT - 1);

    seq_state_t            state;
    logic [SLOT_BITS-1:0]  slot_cnt;
    logic                  win_ready_q;
    logic                  res_valid_q;
    logic [OP_W-1:0]       res_data_q;
    logic                  win_accept;
    logic                  kern_we;

    assign host.win_ready = win_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;

    assign win_accept = host.win_valid && win_ready_q;

    // Kernel is only writable between jobs; out-of-range slots are dropped.
    assign kern_we = host.kern_wr_en && (state == IDLE) && (host.kern_wr_addr <= LAST_SLOT);

    ma_operand_bank #(
        .DEPTH (NSLOT),
        .AW    (SLOT_BITS),
        .DW    (OP_W)
    ) u_kernel_bank (
        .clk   (clk),
        .clr   (rst),
        .we    (kern_we),
        .waddr (host.kern_wr_addr),
        .wdata (host.kern_wr_data),
        .flat  (ma_multiplier)
    );

    // slot_cnt is zero in IDLE, so the first accepted word lands in slot 0.
    ma_operand_bank #(
        .DEPTH (NSLOT),
        .AW    (SLOT_BITS),
        .DW    (OP_W)
    ) u_window_bank (
        .clk   (clk),
        .clr   (rst),
        .we    (win_accept),
        .waddr (slot_cnt),
        .wdata (host.win_data),
        .flat  (ma_multiplicand)
    );

`ifdef MA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Job FSM; every output it owns is registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            slot_cnt          <= '0;
            win_ready_q       <= 1'b1;
            busy              <= 1'b0;
            res_valid_q       <= 1'b0;
            res_data_q        <= '0;
            ma_mstart         <= '0;
            ma_direct         <= 1'b0;
            ma_address_select <= '0;
`ifdef MA_TIMEOUT_EN
            tmo_cnt           <= '0;
            err_q             <= 1'b0;
`endif
        end else begin
            ma_mstart <= '0;
`ifdef MA_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_accept) begin
                        state    <= LOAD;
                        slot_cnt <= SLOT_BITS'(1);
                        busy     <= 1'b1;
                    end
                end

                LOAD: begin
                    if (win_accept) begin
                        if (slot_cnt == LAST_SLOT) begin
                            state       <= START;
                            slot_cnt    <= '0;
                            win_ready_q <= 1'b0;
                            ma_mstart   <= '1;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                end

                START: begin
                    state             <= WAIT;
                    ma_direct         <= cfg_direct;
                    ma_address_select <= cfg_addr_sel;
`ifdef MA_TIMEOUT_EN
                    tmo_cnt           <= '0;
`endif
                end

                // Operand banks cannot change here: window writes need win_ready, kernel writes need IDLE.
                WAIT: begin
                    if (ma_final_ready) begin
                        res_data_q  <= ma_final_accumulate;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
`ifdef MA_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q       <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        win_ready_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                HOLD: begin
                    if (host.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        win_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    slot_cnt    <= '0;
                    busy        <= 1'b0;
                    res_valid_q <= 1'b0;
                    win_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
